spi_slave_rx: RTL

//  SPI slave endpoint that consumes the externally generated serial clock (SCLK) rather than producing it.

---
 rtl/spi_slave_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave endpoint clocked by the system clock.
// SCLK, CS_N and MOSI are oversampled through synchronisers. MOSI is
// deserialised into words (valid/ready on the RX side). TX_DATA is
// serialised onto MISO, and a load strobe is raised each time a word is
// captured.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sclk, cs_n, mosi  SPI pins from the master (asynchronous to clk)
//   miso              serial data to the master
//   rx_data/rx_valid/rx_ready  received word handshake
//   tx_data/tx_load   word for the next frame / capture strobe
//   overrun           pulse when a completed word is dropped
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first framing
// (default is MSB-first).
module spi_slave_rx #(
   parameter int unsigned DATA_W      = 8,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_load,
   output logic              overrun
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sclk_ff, cs_ff, mosi_ff;
   logic                    sclk_q, cs_q;
   logic [CNT_W-1:0]        cnt;
   logic [DATA_W-2:0]       rx_shift;   // first DATA_W-1 bits of the frame
   logic [DATA_W-1:0]       tx_shift;
   logic                    first_shift;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, sample_edge, shift_edge, cs_fall, cs_rise;
   logic [DATA_W-1:0] rx_next, tx_next;
   logic [DATA_W-2:0] rx_keep;
   logic tx_first, tx_second, load_first;

   assign sclk_s = sclk_ff[SYNC_STAGES-1];
   assign cs_s   = cs_ff[SYNC_STAGES-1];
   assign mosi_s = mosi_ff[SYNC_STAGES-1];

   assign sclk_rise   = sclk_s & ~sclk_q;
   assign sclk_fall   = ~sclk_s & sclk_q;
   assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
   assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;
   assign cs_fall     = cs_q & ~cs_s;
   assign cs_rise     = ~cs_q & cs_s;

   // Bit-order specific shift paths; rx_next is the full word including the current bit.
`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign rx_next    = {mosi_s, rx_shift};
   assign rx_keep    = rx_next[DATA_W-1:1];
   assign tx_next    = {1'b0, tx_shift[DATA_W-1:1]};
   assign tx_first   = tx_shift[0];
   assign tx_second  = tx_shift[1];
   assign load_first = tx_data[0];
`else
   assign rx_next    = {rx_shift, mosi_s};
   assign rx_keep    = rx_next[DATA_W-2:0];
   assign tx_next    = {tx_shift[DATA_W-2:0], 1'b0};
   assign tx_first   = tx_shift[DATA_W-1];
   assign tx_second  = tx_shift[DATA_W-2];
   assign load_first = tx_data[DATA_W-1];
`endif

   // Input synchronisers plus one extra copy of SCLK/CS_N for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_ff <= {SYNC_STAGES{CPOL}};
         cs_ff   <= {SYNC_STAGES{1'b1}};
         mosi_ff <= '0;
         sclk_q  <= CPOL;
         cs_q    <= 1'b1;
      end else begin
         sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], sclk};
         cs_ff   <= {cs_ff[SYNC_STAGES-2:0], cs_n};
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
         sclk_q  <= sclk_s;
         cs_q    <= cs_s;
      end
   end

   // Frame FSM and datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         first_shift <= 1'b0;
         miso        <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_load     <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         tx_load <= 1'b0;
         overrun <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (cs_fall) begin
                  tx_shift    <= tx_data;
                  tx_load     <= 1'b1;
                  cnt         <= '0;
                  first_shift <= 1'b1;
                  if (!CPHA) miso <= load_first;
                  state       <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (sample_edge) begin
                  rx_shift <= rx_keep;
                  if (cnt == LAST_BIT) begin
                     cnt <= '0;
                     // A word being handed off this cycle frees the output register.
                     if (!rx_valid || rx_ready) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     tx_shift    <= tx_data;
                     tx_load     <= 1'b1;
                     first_shift <= 1'b1;
                     if (!CPHA) miso <= load_first;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else if (shift_edge) begin
                  if (CPHA && first_shift) begin
                     miso        <= tx_first;
                     first_shift <= 1'b0;
                  end else if (CPHA || cnt != '0) begin
                     // In CPHA=0 the trailing edge after the last sample must not disturb the new word.
                     tx_shift <= tx_next;
                     miso     <= tx_second;
                  end
               end
               if (cs_rise) begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
